// File: rtl/button_input_bank.sv
// button_input_bank: multi-channel button conditioner.
// Each channel normalises polarity, synchronises, debounces, and emits
// registered one-cycle event pulses (press, release, long-press, auto-repeat).
// Channels are fully independent and built from one lane module per channel.
//
// Ports:
//   Clk          system clock
//   RstN         asynchronous active-low reset
//   BtnRaw       raw asynchronous button inputs, one bit per channel
//   RepeatEnable per-channel auto-repeat enable (synchronous to Clk)
//   Level        debounced pressed state (1 = pressed)
//   PressPulse   one-cycle pulse on accepted press
//   ReleasePulse one-cycle pulse on accepted release
//   LongPulse    one-cycle pulse when hold reaches LONG_PRESS_CYCLES
//   RepeatPulse  one-cycle pulses every REPEAT_CYCLES after LongPulse

// Single-channel lane: synchroniser, debounce, event FSM.
module button_input_bank_lane #(
  parameter bit ACTIVE_LOW        = 1'b1,
  parameter int DEBOUNCE_CYCLES   = 250000,
  parameter int LONG_PRESS_CYCLES = 25000000,
  parameter int REPEAT_CYCLES     = 5000000
) (
  input  logic Clk,
  input  logic RstN,
  input  logic btn_raw,
  input  logic repeat_en,
  output logic level,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse,
  output logic repeat_pulse
);

  localparam int DCW  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int HMAX = (LONG_PRESS_CYCLES > REPEAT_CYCLES) ? LONG_PRESS_CYCLES : REPEAT_CYCLES;
  localparam int HCW  = (HMAX > 1) ? $clog2(HMAX) : 1;

  typedef enum logic [1:0] {IDLE, PRESSED, HELD} state_t;

  logic           p;
  logic [1:0]     sync_pipe;
  logic           s;
  logic [DCW-1:0] dc;
  logic [HCW-1:0] hc;
  logic           accept;
  logic           rise;
  logic           fall;
  state_t         state;

  // Normalised so that 1 always means pressed; reset value 0 = released.
  assign p = ACTIVE_LOW ? ~btn_raw : btn_raw;
  assign s = sync_pipe[1];

  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) sync_pipe <= 2'b00;
    else       sync_pipe <= {sync_pipe[0], p};
  end

  // Accept a level change on the edge the mismatch has lasted long enough.
  // The FSM sees the same accept so its pulses line up with the Level edge.
  assign accept = (s != level) && (dc == DCW'(DEBOUNCE_CYCLES - 1));
  assign rise   = accept & s;
  assign fall   = accept & ~s;

  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      level <= 1'b0;
      dc    <= '0;
    end else if (s == level) begin
      dc <= '0;
    end else if (accept) begin
      level <= s;
      dc    <= '0;
    end else begin
      dc <= dc + 1'b1;
    end
  end

  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      state         <= IDLE;
      hc            <= '0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_pulse    <= 1'b0;
      repeat_pulse  <= 1'b0;
    end else begin
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_pulse    <= 1'b0;
      repeat_pulse  <= 1'b0;
      case (state)
        IDLE: begin
          hc <= '0;
          if (rise) begin
            press_pulse <= 1'b1;
            state       <= PRESSED;
          end
        end
        PRESSED: begin
          if (fall) begin
            release_pulse <= 1'b1;
            state         <= IDLE;
            hc            <= '0;
          end else if (hc == HCW'(LONG_PRESS_CYCLES - 1)) begin
            long_pulse <= 1'b1;
            state      <= HELD;
            hc         <= '0;
          end else begin
            hc <= hc + 1'b1;
          end
        end
        HELD: begin
          // Release wins over a coinciding repeat; a disabled repeat parks
          // hc at 0 so re-enabling restarts a full period.
          if (fall) begin
            release_pulse <= 1'b1;
            state         <= IDLE;
            hc            <= '0;
          end else if (!repeat_en) begin
            hc <= '0;
          end else if (hc == HCW'(REPEAT_CYCLES - 1)) begin
            repeat_pulse <= 1'b1;
            hc           <= '0;
          end else begin
            hc <= hc + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          hc    <= '0;
        end
      endcase
    end
  end

endmodule

module button_input_bank #(
  parameter int CHANNELS          = 4,
  parameter bit ACTIVE_LOW        = 1'b1,
  parameter int DEBOUNCE_CYCLES   = 250000,
  parameter int LONG_PRESS_CYCLES = 25000000,
  parameter int REPEAT_CYCLES     = 5000000
) (
  input  logic                Clk,
  input  logic                RstN,
  input  logic [CHANNELS-1:0] BtnRaw,
  input  logic [CHANNELS-1:0] RepeatEnable,
  output logic [CHANNELS-1:0] Level,
  output logic [CHANNELS-1:0] PressPulse,
  output logic [CHANNELS-1:0] ReleasePulse,
  output logic [CHANNELS-1:0] LongPulse,
  output logic [CHANNELS-1:0] RepeatPulse
);

  for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
    button_input_bank_lane #(
      .ACTIVE_LOW       (ACTIVE_LOW),
      .DEBOUNCE_CYCLES  (DEBOUNCE_CYCLES),
      .LONG_PRESS_CYCLES(LONG_PRESS_CYCLES),
      .REPEAT_CYCLES    (REPEAT_CYCLES)
    ) u_lane (
      .Clk          (Clk),
      .RstN         (RstN),
      .btn_raw      (BtnRaw[g]),
      .repeat_en    (RepeatEnable[g]),
      .level        (Level[g]),
      .press_pulse  (PressPulse[g]),
      .release_pulse(ReleasePulse[g]),
      .long_pulse   (LongPulse[g]),
      .repeat_pulse (RepeatPulse[g])
    );
  end

endmodule

// File: tb/tb_button_input_bank.sv
// Scoreboard bench for button_input_bank (4 channels, active-low,
// debounce 4, long press 10, repeat 3). Stimulus pushes expected output
// snapshots tagged with an absolute cycle; the monitor compares at each
// falling edge and flags any pulse that no entry accounts for.
module tb_button_input_bank;

  localparam int CH = 4;

  logic          Clk = 1'b0;
  logic          RstN;
  logic [CH-1:0] BtnRaw;
  logic [CH-1:0] RepeatEnable;
  logic [CH-1:0] Level, PressPulse, ReleasePulse, LongPulse, RepeatPulse;

  button_input_bank #(
    .CHANNELS(CH), .ACTIVE_LOW(1'b1), .DEBOUNCE_CYCLES(4),
    .LONG_PRESS_CYCLES(10), .REPEAT_CYCLES(3)
  ) dut (
    .Clk(Clk), .RstN(RstN), .BtnRaw(BtnRaw), .RepeatEnable(RepeatEnable),
    .Level(Level), .PressPulse(PressPulse), .ReleasePulse(ReleasePulse),
    .LongPulse(LongPulse), .RepeatPulse(RepeatPulse)
  );

  always #5 Clk = ~Clk;

  // Count of rising edges; cycle N is sampled at the falling edge after edge N.
  int ecnt = 0;
  always @(posedge Clk) ecnt <= ecnt + 1;

  typedef struct {
    int            cyc;
    string         tag;
    logic [CH-1:0] lvl, prs, rel, lng, rep;
  } exp_t;

  exp_t sbq[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;

  task automatic push_exp(input int c, input string tag, input logic [CH-1:0] lvl,
                          input logic [CH-1:0] prs, input logic [CH-1:0] rel,
                          input logic [CH-1:0] lng, input logic [CH-1:0] rep);
    exp_t x;
    x.cyc = c; x.tag = tag; x.lvl = lvl; x.prs = prs; x.rel = rel; x.lng = lng; x.rep = rep;
    sbq.push_back(x);
  endtask

  // Monitor
  always @(negedge Clk) begin
    while (sbq.size() > 0 && sbq[0].cyc < ecnt) begin
      e = sbq.pop_front();
      checks++;
      errors++;
      $display("FAIL %s missed expectation at cycle %0d (now %0d)", e.tag, e.cyc, ecnt);
    end
    if (sbq.size() > 0 && sbq[0].cyc == ecnt) begin
      e = sbq.pop_front();
      checks++;
      if ({Level, PressPulse, ReleasePulse, LongPulse, RepeatPulse} !==
          {e.lvl, e.prs, e.rel, e.lng, e.rep}) begin
        errors++;
        $display("FAIL %s cyc=%0d got lvl=%b prs=%b rel=%b lng=%b rep=%b want lvl=%b prs=%b rel=%b lng=%b rep=%b",
                 e.tag, ecnt, Level, PressPulse, ReleasePulse, LongPulse, RepeatPulse,
                 e.lvl, e.prs, e.rel, e.lng, e.rep);
      end
    end else if (|{PressPulse, ReleasePulse, LongPulse, RepeatPulse}) begin
      checks++;
      errors++;
      $display("FAIL unexpected_pulse cyc=%0d got prs=%b rel=%b lng=%b rep=%b want none",
               ecnt, PressPulse, ReleasePulse, LongPulse, RepeatPulse);
    end
  end

  task automatic wait_to(input int c);
    while (ecnt < c) @(negedge Clk);
  endtask

  // Monitor pops stale entries itself, so this always completes.
  task automatic drain();
    int n = 0;
    while (sbq.size() > 0 && n < 200) begin
      @(negedge Clk);
      n++;
    end
    repeat (4) @(negedge Clk);
  endtask

  int t;

  initial begin
    RstN         = 1'b0;
    BtnRaw       = '1;
    RepeatEnable = '0;

    // Reset state
    push_exp(1, "reset", 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    push_exp(2, "reset", 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    wait_to(3);
    RstN = 1'b1;
    push_exp(5, "idle", 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    drain();

    // Clean press + concurrency: ch0 and ch3 pressed, ch3 released at 8
    @(negedge Clk); t = ecnt;
    BtnRaw = 4'b0110;
    push_exp(t+5,  "conc_pre",   4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    push_exp(t+6,  "conc_press", 4'b1001, 4'b1001, 4'b0000, 4'b0000, 4'b0000);
    push_exp(t+7,  "conc_lvl",   4'b1001, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    push_exp(t+13, "conc_lvl",   4'b1001, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    push_exp(t+14, "conc_rel3",  4'b0001, 4'b0000, 4'b1000, 4'b0000, 4'b0000);
    push_exp(t+16, "conc_long0", 4'b0001, 4'b0000, 4'b0000, 4'b0001, 4'b0000);
    push_exp(t+20, "conc_held0", 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    push_exp(t+26, "conc_rel0",  4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0000);
    push_exp(t+27, "conc_idle",  4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    wait_to(t+8);  BtnRaw[3] = 1'b1;
    wait_to(t+20); BtnRaw[0] = 1'b1;
    drain();

    // Bounce: ch1 low for 3 cycles only
    @(negedge Clk); t = ecnt;
    BtnRaw[1] = 1'b0;
    for (int k = 4; k <= 10; k += 2)
      push_exp(t+k, "bounce", 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    wait_to(t+3); BtnRaw[1] = 1'b1;
    drain();

    // Long + repeat on ch2; release lands Level fall on a would-be repeat
    @(negedge Clk); t = ecnt;
    RepeatEnable = 4'b0100;
    BtnRaw[2]    = 1'b0;
    push_exp(t+6,  "lr_press", 4'b0100, 4'b0100, 4'b0000, 4'b0000, 4'b0000);
    push_exp(t+16, "lr_long",  4'b0100, 4'b0000, 4'b0000, 4'b0100, 4'b0000);
    push_exp(t+19, "lr_rep1",  4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0100);
    push_exp(t+22, "lr_rep2",  4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0100);
    push_exp(t+25, "lr_rep3",  4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0100);
    push_exp(t+27, "lr_held",  4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    push_exp(t+28, "lr_rel",   4'b0000, 4'b0000, 4'b0100, 4'b0000, 4'b0000);
    push_exp(t+31, "lr_idle",  4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    wait_to(t+22); BtnRaw[2] = 1'b1;
    drain();

    // Repeat disabled, then enabled at 20
    @(negedge Clk); t = ecnt;
    RepeatEnable = 4'b0000;
    BtnRaw[2]    = 1'b0;
    push_exp(t+6,  "tg_press", 4'b0100, 4'b0100, 4'b0000, 4'b0000, 4'b0000);
    push_exp(t+16, "tg_long",  4'b0100, 4'b0000, 4'b0000, 4'b0100, 4'b0000);
    push_exp(t+20, "tg_norep", 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    push_exp(t+23, "tg_rep1",  4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0100);
    push_exp(t+26, "tg_rep2",  4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0100);
    push_exp(t+29, "tg_rep3",  4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0100);
    push_exp(t+30, "tg_rel",   4'b0000, 4'b0000, 4'b0100, 4'b0000, 4'b0000);
    wait_to(t+20); RepeatEnable[2] = 1'b1;
    wait_to(t+24); BtnRaw[2] = 1'b1;
    drain();

    // Reset mid-repeat with ch2 still held
    @(negedge Clk); t = ecnt;
    BtnRaw[2] = 1'b0;
    push_exp(t+6,  "rs_press",  4'b0100, 4'b0100, 4'b0000, 4'b0000, 4'b0000);
    push_exp(t+16, "rs_long",   4'b0100, 4'b0000, 4'b0000, 4'b0100, 4'b0000);
    push_exp(t+19, "rs_rep",    4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0100);
    push_exp(t+20, "rs_zero",   4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    push_exp(t+22, "rs_zero",   4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    push_exp(t+25, "rs_zero",   4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    push_exp(t+30, "rs_pre",    4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    push_exp(t+31, "rs_press2", 4'b0100, 4'b0100, 4'b0000, 4'b0000, 4'b0000);
    push_exp(t+41, "rs_long2",  4'b0100, 4'b0000, 4'b0000, 4'b0100, 4'b0000);
    push_exp(t+44, "rs_rep2a",  4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0100);
    push_exp(t+47, "rs_rep2b",  4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0100);
    push_exp(t+48, "rs_rel",    4'b0000, 4'b0000, 4'b0100, 4'b0000, 4'b0000);
    wait_to(t+19);
    @(posedge Clk);
    #1 RstN = 1'b0;
    wait_to(t+25); RstN = 1'b1;
    wait_to(t+42); BtnRaw[2] = 1'b1;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
